mem_arbiter: RTL and testbench

Shares one single-port, variable-latency memory between the instruction-fetch port and the MEM-stage data port of the pipelined RV32I core. Data accesses have priority, with a bounded-starvation guard for fetch. The block also converts the MEM-stage control fields (length, sign, active-low write enable) into byte enables, lane-replicated write data and sign- or zero-extended read data. It sits between the pipeline's IF and MEM stages and the memory.

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter_lane_align.sv | 59 +++++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory arbiter: FSM encoding, MEM-stage
// access-length codes, write-enable polarity and the alignment rule.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        D_ERR  = 2'd3
    } arb_state_e;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    // The decoder drives the MEM write enable low for stores.
    localparam logic WEN_ACTIVE = 1'b0;

    function automatic logic is_misaligned(input logic [1:0] addr, input logic [1:0] len);
        logic bad;
        bad = 1'b1;
        case (len)
            LEN_B:   bad = 1'b0;
            LEN_H:   bad = addr[0];
            LEN_W:   bad = (addr != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// Byte-lane steering between the right-aligned MEM-stage view of data and the
// word-wide memory: store byte enables and replication, load extraction and extension.
module lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  len,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (len)
            LEN_B: begin
                be        = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
            end
            LEN_H: begin
                be        = 4'b0011 << addr;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel = rdata_raw[7:0];
        case (addr)
            2'd0: byte_sel = rdata_raw[7:0];
            2'd1: byte_sel = rdata_raw[15:8];
            2'd2: byte_sel = rdata_raw[23:16];
            2'd3: byte_sel = rdata_raw[31:24];
            default: byte_sel = rdata_raw[7:0];
        endcase
        half_sel = addr[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    end

    always_comb begin
        rdata_ext = rdata_raw;
        case (len)
            LEN_B:   rdata_ext = {{24{sign & byte_sel[7]}}, byte_sel};
            LEN_H:   rdata_ext = {{16{sign & half_sel[15]}}, half_sel};
            default: rdata_ext = rdata_raw;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and MEM-stage data,
// with data priority bounded so a pending fetch wins after MAX_DATA_BURST data grants.
module mem_arbiter #(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    input  logic        instr_flush_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_wen_i,
    input  logic [1:0]  data_len_i,
    input  logic        data_sign_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_done_o,
    output logic [31:0] data_rdata_o,
    output logic        data_misalign_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);

    import mem_arbiter_pkg::*;

    localparam int CW = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_DATA_BURST);

    arb_state_e    state;
    arb_state_e    next_state;
    logic [CW-1:0] burst_cnt;
    logic          flush_pending;

    logic          instr_req_eff;
    logic          data_req_eff;
    logic          fetch_forced;
    logic          grant_data;
    logic          grant_instr;
    logic          data_misaligned;

    logic [3:0]    align_be;
    logic [31:0]   align_wdata;
    logic [31:0]   align_rdata;

    logic          unused_addr_bits;
    assign unused_addr_bits = ^instr_addr_i[1:0];

    // MEM-stage fields stay stable until data_done_o, so both lane paths use them live.
    lane_align u_lane_align (
        .addr      (data_addr_i[1:0]),
        .len       (data_len_i),
        .sign      (data_sign_i),
        .wdata     (data_wdata_i),
        .rdata_raw (mem_rdata_i),
        .be        (align_be),
        .wdata_rep (align_wdata),
        .rdata_ext (align_rdata)
    );

    assign mem_req_o = (state == BUSY_I) || (state == BUSY_D);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A requester whose completion pulse is high is masked so its held request is not re-granted.
    always_comb begin
        next_state      = state;
        instr_req_eff   = instr_req_i && !instr_valid_o;
        data_req_eff    = data_req_i && !data_done_o;
        fetch_forced    = instr_req_eff && !instr_flush_i && (burst_cnt == BURST_MAX);
        data_misaligned = is_misaligned(data_addr_i[1:0], data_len_i);
        grant_data      = 1'b0;
        grant_instr     = 1'b0;
        case (state)
            IDLE: begin
                if (data_req_eff && !fetch_forced) begin
                    grant_data = 1'b1;
                    next_state = data_misaligned ? D_ERR : BUSY_D;
                end else if (instr_req_eff && !instr_flush_i) begin
                    grant_instr = 1'b1;
                    next_state  = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready_i) begin
                    next_state = IDLE;
                end
            end
            D_ERR: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            burst_cnt       <= '0;
            flush_pending   <= 1'b0;
            instr_valid_o   <= 1'b0;
            instr_rdata_o   <= '0;
            data_done_o     <= 1'b0;
            data_rdata_o    <= '0;
            data_misalign_o <= 1'b0;
            mem_addr_o      <= '0;
            mem_we_o        <= 1'b0;
            mem_be_o        <= '0;
            mem_wdata_o     <= '0;
        end else begin
            instr_valid_o   <= 1'b0;
            data_done_o     <= 1'b0;
            data_misalign_o <= 1'b0;

            if (grant_data) begin
                if (burst_cnt != BURST_MAX) begin
                    burst_cnt <= burst_cnt + CW'(1);
                end
                if (!data_misaligned) begin
                    mem_addr_o  <= {data_addr_i[31:2], 2'b00};
                    mem_we_o    <= (data_wen_i == WEN_ACTIVE);
                    mem_be_o    <= align_be;
                    mem_wdata_o <= align_wdata;
                end
            end else if (grant_instr) begin
                burst_cnt   <= '0;
                mem_addr_o  <= {instr_addr_i[31:2], 2'b00};
                mem_we_o    <= 1'b0;
                mem_be_o    <= 4'b1111;
                mem_wdata_o <= '0;
            end

            // A redirect seen at any point of the fetch, including its last cycle, drops the word.
            if (state == BUSY_I) begin
                if (mem_ready_i) begin
                    flush_pending <= 1'b0;
                    if (!(flush_pending || instr_flush_i)) begin
                        instr_valid_o <= 1'b1;
                        instr_rdata_o <= mem_rdata_i;
                    end
                end else begin
                    flush_pending <= flush_pending || instr_flush_i;
                end
            end else begin
                flush_pending <= 1'b0;
            end

            if (state == BUSY_D && mem_ready_i) begin
                data_done_o  <= 1'b1;
                data_rdata_o <= mem_we_o ? 32'h0 : align_rdata;
            end

            if (state == D_ERR) begin
                data_done_o     <= 1'b1;
                data_misalign_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: lane steering, arbitration limit, misalignment,
// flush suppression and mid-access reset, each step checked against hand values.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_flush_i;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_wen_i;
    logic [1:0]  data_len_i;
    logic        data_sign_i;
    logic [31:0] data_wdata_i;
    logic        data_done_o;
    logic [31:0] data_rdata_o;
    logic        data_misalign_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;

    int compared   = 0;
    int mismatched = 0;

    mem_arbiter #(.MAX_DATA_BURST(4)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .instr_req_i     (instr_req_i),
        .instr_addr_i    (instr_addr_i),
        .instr_flush_i   (instr_flush_i),
        .instr_valid_o   (instr_valid_o),
        .instr_rdata_o   (instr_rdata_o),
        .data_req_i      (data_req_i),
        .data_addr_i     (data_addr_i),
        .data_wen_i      (data_wen_i),
        .data_len_i      (data_len_i),
        .data_sign_i     (data_sign_i),
        .data_wdata_i    (data_wdata_i),
        .data_done_o     (data_done_o),
        .data_rdata_o    (data_rdata_o),
        .data_misalign_o (data_misalign_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_ready_i     (mem_ready_i),
        .mem_rdata_i     (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic wen,
                                 input logic [1:0] len, input logic sign, input logic [31:0] wdata);
        data_req_i   = req;
        data_addr_i  = addr;
        data_wen_i   = wen;
        data_len_i   = len;
        data_sign_i  = sign;
        data_wdata_i = wdata;
    endtask

    initial begin
        reset_i       = 1'b0;
        instr_req_i   = 1'b0;
        instr_addr_i  = '0;
        instr_flush_i = 1'b0;
        mem_ready_i   = 1'b0;
        mem_rdata_i   = '0;
        applyStimulus(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
        checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
        checkOutput("rst_mem_be", {28'b0, mem_be_o}, 32'h0);
        checkOutput("rst_done", {31'b0, data_done_o}, 32'h0);
        checkOutput("rst_ivalid", {31'b0, instr_valid_o}, 32'h0);
        checkOutput("rst_drdata", data_rdata_o, 32'h0);
        reset_i = 1'b1;
        tick();

        // Store byte at 0x103
        applyStimulus(1'b1, 32'h0000_0103, 1'b0, 2'd0, 1'b0, 32'h0000_00A5);
        tick();
        checkOutput("sb_req", {31'b0, mem_req_o}, 32'h1);
        checkOutput("sb_addr", mem_addr_o, 32'h0000_0100);
        checkOutput("sb_be", {28'b0, mem_be_o}, 32'h8);
        checkOutput("sb_wdata", mem_wdata_o, 32'hA5A5_A5A5);
        checkOutput("sb_we", {31'b0, mem_we_o}, 32'h1);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        checkOutput("sb_done", {31'b0, data_done_o}, 32'h1);
        checkOutput("sb_misalign", {31'b0, data_misalign_o}, 32'h0);
        checkOutput("sb_req_drop", {31'b0, mem_req_o}, 32'h0);
        checkOutput("sb_rdata", data_rdata_o, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
        tick();
        checkOutput("sb_done_pulse", {31'b0, data_done_o}, 32'h0);

        // Signed then unsigned half load at 0x102
        applyStimulus(1'b1, 32'h0000_0102, 1'b1, 2'd1, 1'b1, 32'h0);
        tick();
        checkOutput("lh_be", {28'b0, mem_be_o}, 32'hC);
        checkOutput("lh_we", {31'b0, mem_we_o}, 32'h0);
        mem_rdata_i = 32'h8001_0000;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        checkOutput("lh_done", {31'b0, data_done_o}, 32'h1);
        checkOutput("lh_signed", data_rdata_o, 32'hFFFF_8001);
        applyStimulus(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h0000_0102, 1'b1, 2'd1, 1'b0, 32'h0);
        tick();
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        checkOutput("lhu_rdata", data_rdata_o, 32'h0000_8001);
        applyStimulus(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
        tick();

        // Misaligned word load at 0x6: no memory cycle, rdata kept
        applyStimulus(1'b1, 32'h0000_0006, 1'b1, 2'd2, 1'b0, 32'h0);
        tick();
        checkOutput("mis_req_k1", {31'b0, mem_req_o}, 32'h0);
        checkOutput("mis_done_k1", {31'b0, data_done_o}, 32'h0);
        tick();
        checkOutput("mis_done", {31'b0, data_done_o}, 32'h1);
        checkOutput("mis_flag", {31'b0, data_misalign_o}, 32'h1);
        checkOutput("mis_req_k2", {31'b0, mem_req_o}, 32'h0);
        checkOutput("mis_rdata", data_rdata_o, 32'h0000_8001);
        applyStimulus(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
        tick();
        checkOutput("mis_flag_pulse", {31'b0, data_misalign_o}, 32'h0);

        // Four data grants so far with no fetch: a simultaneous fetch must now win
        applyStimulus(1'b1, 32'h0000_0040, 1'b1, 2'd2, 1'b0, 32'h0);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0507;
        tick();
        checkOutput("bl_fetch_addr", mem_addr_o, 32'h0000_0504);
        checkOutput("bl_fetch_be", {28'b0, mem_be_o}, 32'hF);
        checkOutput("bl_fetch_we", {31'b0, mem_we_o}, 32'h0);
        mem_rdata_i = 32'hCAFE_F00D;
        mem_ready_i = 1'b1;
        tick();
        checkOutput("bl_ivalid", {31'b0, instr_valid_o}, 32'h1);
        checkOutput("bl_irdata", instr_rdata_o, 32'hCAFE_F00D);
        checkOutput("bl_ddone", {31'b0, data_done_o}, 32'h0);
        instr_req_i = 1'b0;
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'h1122_3344;
        tick();
        checkOutput("bl_data_req", {31'b0, mem_req_o}, 32'h1);
        checkOutput("bl_data_addr", mem_addr_o, 32'h0000_0040);
        checkOutput("bl_ivalid_pulse", {31'b0, instr_valid_o}, 32'h0);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        checkOutput("bl_data_done", {31'b0, data_done_o}, 32'h1);
        checkOutput("bl_data_rdata", data_rdata_o, 32'h1122_3344);
        applyStimulus(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
        tick();

        // Burst count is 1: data wins, then the done-cycle mask lets the held fetch in
        applyStimulus(1'b1, 32'h0000_0044, 1'b1, 2'd2, 1'b0, 32'h0);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0600;
        tick();
        checkOutput("pr_data_addr", mem_addr_o, 32'h0000_0044);
        mem_rdata_i = 32'h5566_7788;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        checkOutput("pr_data_rdata", data_rdata_o, 32'h5566_7788);
        tick();
        checkOutput("pr_mask_req", {31'b0, mem_req_o}, 32'h1);
        checkOutput("pr_mask_addr", mem_addr_o, 32'h0000_0600);
        applyStimulus(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
        mem_rdata_i = 32'h0BAD_F00D;
        mem_ready_i = 1'b1;
        tick();
        checkOutput("pr_ivalid", {31'b0, instr_valid_o}, 32'h1);
        checkOutput("pr_irdata", instr_rdata_o, 32'h0BAD_F00D);
        instr_req_i = 1'b0;
        mem_ready_i = 1'b0;
        tick();
        checkOutput("pr_idle", {31'b0, mem_req_o}, 32'h0);

        // Fetch stalled three cycles with a flush in the middle
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0200;
        tick();
        checkOutput("fl_addr", mem_addr_o, 32'h0000_0200);
        tick();
        instr_flush_i = 1'b1;
        tick();
        instr_flush_i = 1'b0;
        instr_addr_i  = 32'h0000_0300;
        tick();
        checkOutput("fl_stall_req", {31'b0, mem_req_o}, 32'h1);
        checkOutput("fl_stall_addr", mem_addr_o, 32'h0000_0200);
        mem_rdata_i = 32'hDEAD_BEEF;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        checkOutput("fl_suppress", {31'b0, instr_valid_o}, 32'h0);
        checkOutput("fl_rdata_hold", instr_rdata_o, 32'h0BAD_F00D);
        checkOutput("fl_idle_req", {31'b0, mem_req_o}, 32'h0);
        tick();
        checkOutput("fl_new_req", {31'b0, mem_req_o}, 32'h1);
        checkOutput("fl_new_addr", mem_addr_o, 32'h0000_0300);
        mem_rdata_i = 32'h1357_9BDF;
        mem_ready_i = 1'b1;
        tick();
        checkOutput("fl_new_valid", {31'b0, instr_valid_o}, 32'h1);
        checkOutput("fl_new_rdata", instr_rdata_o, 32'h1357_9BDF);
        instr_req_i = 1'b0;
        mem_ready_i = 1'b0;
        tick();

        // Reset in the middle of a stalled store
        applyStimulus(1'b1, 32'h0000_0080, 1'b0, 2'd2, 1'b0, 32'h1234_5678);
        tick();
        checkOutput("rs_wdata", mem_wdata_o, 32'h1234_5678);
        tick();
        tick();
        reset_i = 1'b0;
        #1;
        checkOutput("rs_req", {31'b0, mem_req_o}, 32'h0);
        checkOutput("rs_addr", mem_addr_o, 32'h0);
        checkOutput("rs_wdata0", mem_wdata_o, 32'h0);
        checkOutput("rs_irdata", instr_rdata_o, 32'h0);
        checkOutput("rs_drdata", data_rdata_o, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
        tick();
        reset_i = 1'b1;
        tick();
        checkOutput("rs_no_done", {31'b0, data_done_o}, 32'h0);
        checkOutput("rs_idle", {31'b0, mem_req_o}, 32'h0);
        applyStimulus(1'b1, 32'h0000_0081, 1'b1, 2'd0, 1'b1, 32'h0);
        tick();
        checkOutput("rs_lb_be", {28'b0, mem_be_o}, 32'h2);
        checkOutput("rs_lb_addr", mem_addr_o, 32'h0000_0080);
        mem_rdata_i = 32'h0000_8000;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        checkOutput("rs_lb_done", {31'b0, data_done_o}, 32'h1);
        checkOutput("rs_lb_rdata", data_rdata_o, 32'hFFFF_FF80);
        applyStimulus(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
